// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor (a - b - bin), LSB first, one full-subtractor bit per clock.
// Optional macro SERIAL_SUB_OVF_EN adds a two's-complement overflow output ovf.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               br_q;

  logic               bit_a_c;
  logic               bit_b_c;
  logic               diff_bit_c;
  logic               br_d;
  logic [WIDTH-1:0]   res_d;
  logic               last_bit_c;

  // Full-subtractor on the current bit plus the shifted result image.
  always_comb begin
    bit_a_c    = a_q[cnt_q];
    bit_b_c    = b_q[cnt_q];
    diff_bit_c = bit_a_c ^ bit_b_c ^ br_q;
    br_d       = (~bit_a_c & bit_b_c) | (~bit_a_c & br_q) | (bit_b_c & br_q);
    res_d      = {diff_bit_c, res_q[WIDTH-1:1]};
    last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Control FSM with registered busy/done and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_q <= RUN;
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            res_q   <= '0;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          res_q <= res_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_bit_c) begin
            state_q <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            diff    <= res_d;
            bout    <= br_d;
`ifdef SERIAL_SUB_OVF_EN
            // Overflow only when operand signs differ and the result sign leaves a's sign.
            ovf     <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_bit_c != a_q[WIDTH-1]);
`endif
          end
        end
        DONE: begin
          state_q <= IDLE;
          done    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl against an arithmetic reference model.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks;
  int failures;
  int cyc;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain (W+1)-bit arithmetic; MSB of the result is the borrow.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] r;
    r = {1'b0, x} - {1'b0, y} - (W+1)'(c);
    return r;
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c);
    logic [W:0] r;
    r = ref_sub(x, y, c);
    return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  function automatic logic get_ovf();
`ifdef SERIAL_SUB_OVF_EN
    return ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Drives one operation and gathers timing observations; comparisons happen in callers.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        input bit inject,
                        output logic [W-1:0] odiff, output logic obout, output logic oovf,
                        output int busy_cnt, output int lat,
                        output bit partial_bad, output bit extra_done);
    logic [W-1:0] prev;
    busy_cnt = 0; lat = 0; partial_bad = 0; extra_done = 0;
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; bin = ibin;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    prev = diff;
    if (busy) busy_cnt++;
    for (int n = 1; n <= W + 6; n++) begin
      if (inject) begin
        start = (n == 2 || n == 8);
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_cnt++;
      if (diff !== prev) partial_bad = 1;
    end
    start = 1'b0;
    odiff = diff; obout = bout; oovf = get_ovf();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done) extra_done = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h55; bin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, diff, bout} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b diff=%h bout=%b want all 0",
               busy, done, diff, bout);
    end
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_start_ignored got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ibin, input bit inject);
    logic [W-1:0] d; logic bo; logic ov; int bc; int lat; bit pb; bit ed;
    logic [W:0] exp;
    exp = ref_sub(ia, ib, ibin);
    run_op(ia, ib, ibin, inject, d, bo, ov, bc, lat, pb, ed);
    checks++;
    if (d !== exp[W-1:0] || bo !== exp[W]) begin
      failures++;
      $display("FAIL %s_result a=%h b=%h bin=%b got diff=%h bout=%b want diff=%h bout=%b",
               name, ia, ib, ibin, d, bo, exp[W-1:0], exp[W]);
    end
    checks++;
    if (lat !== W || bc !== W) begin
      failures++;
      $display("FAIL %s_timing got done_lat=%0d busy_cycles=%0d want %0d %0d",
               name, lat, bc, W, W);
    end
    checks++;
    if (pb !== 1'b0 || ed !== 1'b0) begin
      failures++;
      $display("FAIL %s_pulse got partial_change=%b extra_done=%b want 0 0", name, pb, ed);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ov !== ref_ovf(ia, ib, ibin)) begin
      failures++;
      $display("FAIL %s_ovf got %b want %b", name, ov, ref_ovf(ia, ib, ibin));
    end
`endif
  endtask

  task automatic test_directed();
    check_op("d05_03", 8'h05, 8'h03, 1'b0, 0);
    check_op("d03_05", 8'h03, 8'h05, 1'b0, 0);
    check_op("d00_00_b", 8'h00, 8'h00, 1'b1, 0);
    check_op("dff_ff", 8'hFF, 8'hFF, 1'b0, 0);
    check_op("d80_01", 8'h80, 8'h01, 1'b0, 0);
    check_op("d7f_ff", 8'h7F, 8'hFF, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      check_op("rand", W'($urandom), W'($urandom), 1'($urandom), 0);
  endtask

  task automatic test_ignore_start();
    check_op("ignore_start", 8'h5A, 8'h3C, 1'b1, 1);
  endtask

  task automatic test_reset_mid_run();
    int done_seen;
    check_op("pre_reset", 8'h03, 8'h05, 1'b0, 0);
    @(negedge clk);
    start = 1'b1; a = 8'h77; b = 8'h11; bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, diff, bout} !== '0) begin
      failures++;
      $display("FAIL mid_reset_async got busy=%b done=%b diff=%h bout=%b want all 0",
               busy, done, diff, bout);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL mid_reset_abort got activity_cycles=%0d want 0", done_seen);
    end
    check_op("post_reset", 8'h10, 8'h01, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] oa [3];
    logic [W-1:0] ob [3];
    logic         oc [3];
    logic [W:0]   exp;
    int           t_done [3];
    bit           timeout;
    for (int i = 0; i < 3; i++) begin
      oa[i] = W'($urandom); ob[i] = W'($urandom); oc[i] = 1'($urandom);
    end
    timeout = 0;
    @(negedge clk);
    start = 1'b1; a = oa[0]; b = ob[0]; bin = oc[0];
    for (int i = 0; i < 3; i++) begin
      int n;
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!done && n < 4 * W);
      if (!done) timeout = 1;
      t_done[i] = cyc;
      exp = ref_sub(oa[i], ob[i], oc[i]);
      checks++;
      if (diff !== exp[W-1:0] || bout !== exp[W]) begin
        failures++;
        $display("FAIL b2b_result%0d got diff=%h bout=%b want diff=%h bout=%b",
                 i, diff, bout, exp[W-1:0], exp[W]);
      end
      if (i < 2) begin
        a = oa[i+1]; b = ob[i+1]; bin = oc[i+1];
      end
    end
    start = 1'b0;
    checks++;
    if (timeout || (t_done[1] - t_done[0]) != W + 2 || (t_done[2] - t_done[1]) != W + 2) begin
      failures++;
      $display("FAIL b2b_spacing got gaps=%0d,%0d timeout=%b want %0d",
               t_done[1] - t_done[0], t_done[2] - t_done[1], timeout, W + 2);
    end
    repeat (W + 4) @(posedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; sampled on the accepting edge.
REQ-006 b  input  WIDTH  subtrahend; sampled on the accepting edge.
REQ-007 bin  input  1  borrow-in; sampled on the accepting edge.
REQ-008 busy  output  1  high while an operation is in progress (RUN state).
REQ-009 done  output  1  one-cycle pulse; diff/bout valid.
REQ-010 diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-011 bout  output  1  final borrow-out, set when a < b + bin (unsigned).

Function
REQ-012 The block SHALL compute the difference bit-serially, LSB first, one full-subtractor bit per clock, using a single 1-bit borrow register.
REQ-013 Per-bit rule: d = a[i] ^ b[i] ^ br; br_next = (~a[i] & b[i]) | (~a[i] & br) | (b[i] & br).
REQ-014 FSM states SHALL be IDLE, RUN and DONE only; any other encoding returns to IDLE on the next edge.
REQ-015 IDLE -> RUN on an edge with start=1: latch a, b into operand registers, set br=bin, clear bit counter to 0, set busy=1.
REQ-016 RUN: each edge processes bit counter index, increments counter; after the edge processing bit WIDTH-1, go to DONE.
REQ-017 DONE: done=1, busy=0 for exactly one cycle; next edge returns to IDLE, done=0.
REQ-018 Latency: start accepted at edge E0; busy high for exactly WIDTH cycles; done high in the cycle following edge E(WIDTH); earliest next accept at edge E(WIDTH+2).
REQ-019 diff and bout SHALL update only on entry to DONE (both at once) and hold their value until the next DONE; partial results are never visible on diff.
REQ-020 start while in RUN or DONE SHALL be ignored, with no effect on operands, counter or results.
REQ-021 a, b, bin changes after the accepting edge SHALL have no effect on the operation in progress.
REQ-022 start held continuously SHALL produce back-to-back operations, each accepted in IDLE.

Reset
REQ-023 rst=1 SHALL asynchronously force: state IDLE, busy=0, done=0, diff=0, bout=0, counter=0, borrow register=0, operand registers=0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be serviced normally.
REQ-025 start sampled on the same edge at which rst deasserts is ignored only if rst is still high at that edge.

Configuration
REQ-026 Macro SERIAL_SUB_OVF_EN: when defined, output port ovf (1 bit) SHALL exist, updated with diff on DONE entry, equal to two's-complement overflow: (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using latched operands; reset value 0.
REQ-027 When SERIAL_SUB_OVF_EN is not defined, port ovf and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 WIDTH=8, a=0x05 b=0x03 bin=0, start 1 cycle -> busy high 8 cycles, done pulse in 9th cycle after accept, diff=0x02 bout=0.
REQ-029 WIDTH=8, a=0x03 b=0x05 bin=0 -> diff=0xFE bout=1; then a=0x00 b=0x00 bin=1 -> diff=0xFF bout=1; a=0xFF b=0xFF bin=0 -> diff=0x00 bout=0.
REQ-030 Start pulsed again at cycles 2 and 8 of RUN with different operands -> ignored; result still from first operands; single done pulse.
REQ-031 rst asserted at RUN cycle 4 -> busy, done, diff, bout all 0 immediately (before next edge); no done; new start a=0x10 b=0x01 -> diff=0x0F bout=0.
REQ-032 SERIAL_SUB_OVF_EN defined: a=0x80 b=0x01 bin=0 -> diff=0x7F ovf=1 bout=0; a=0x7F b=0xFF -> diff=0x80 ovf=1 bout=1; a=0x05 b=0x03 -> ovf=0.
REQ-033 start held high 3 operations -> done pulses exactly WIDTH+2 cycles apart, each result correct.
